// File: rtl/token_pacer.sv
// Token pacer: queues 1-bit tokens in a saturating counter and re-emits them
// one pulse at a time, at least GAP idle cycles apart, whenever ready is high.
module token_pacer #(
   parameter int CNT_W = 3,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             ready,
   output logic             b,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] MAX      = '1;
   localparam int               GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [GW-1:0]    GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EMIT,
      S_GAP
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_pending;
   logic [CNT_W-1:0] w_pending_next;
   logic [GW-1:0]    r_gap_cnt;
   logic [GW-1:0]    w_gap_cnt_next;
   logic             r_overflow;
   logic             w_b;
   logic             w_drop;

   assign w_b = (r_state == S_EMIT) & ready;

   // A token arriving while full is dropped unless a pulse frees a slot the same cycle.
   assign w_drop = a & ~w_b & (r_pending == MAX);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      w_pending_next = r_pending;
      if (a & ~w_b & ~w_drop) begin
         w_pending_next = r_pending + CNT_W'(1);
      end else if (~a & w_b) begin
         w_pending_next = r_pending - CNT_W'(1);
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_gap_cnt_next = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            if (a) begin
               w_state_next = S_EMIT;
            end
         end
         S_EMIT: begin
            if (w_b) begin
               if (GAP > 0) begin
                  w_state_next   = S_GAP;
                  w_gap_cnt_next = GAP_LOAD;
               end else begin
                  w_state_next = (w_pending_next != '0) ? S_EMIT : S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt != '0) begin
               w_gap_cnt_next = r_gap_cnt - GW'(1);
            end else begin
               w_state_next = (w_pending_next != '0) ? S_EMIT : S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pending  <= '0;
         r_gap_cnt  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pending  <= w_pending_next;
         r_gap_cnt  <= w_gap_cnt_next;
         r_overflow <= r_overflow | w_drop;
      end
   end

   assign b        = w_b;
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_token_pacer.sv
// Scoreboard bench for token_pacer: expected pulse cycles are queued by the
// stimulus and consumed by a monitor that watches b.
module tb_token_pacer;

   logic       clk = 1'b0;
   logic       rst;
   logic       a;
   logic       ready;
   logic       b;
   logic [2:0] pending;
   logic       overflow;

   logic       a0;
   logic       ready0;
   logic       b0;
   logic [2:0] pending0;
   logic       overflow0;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int n_b0   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   token_pacer #(.CNT_W(3), .GAP(2)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .ready    (ready),
      .b        (b),
      .pending  (pending),
      .overflow (overflow)
   );

   token_pacer #(.CNT_W(3), .GAP(0)) u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .a        (a0),
      .ready    (ready0),
      .b        (b0),
      .pending  (pending0),
      .overflow (overflow0)
   );

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Each b pulse must match the next scheduled cycle; an unscheduled pulse fails.
   always @(negedge clk) begin
      if (b === 1'b1) begin
         if (exp_q.size() == 0) check("b_unexpected", cyc, -1);
         else                   check("b_cycle", cyc, exp_q.pop_front());
      end
      if (b0 === 1'b1) n_b0++;
   end

   task automatic step(input logic a_v, input logic r_v);
      a     = a_v;
      ready = r_v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int c;
      int n_in;
      int owed;
      rst    = 1'b1;
      a      = 1'b0;
      ready  = 1'b0;
      a0     = 1'b0;
      ready0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_b", int'(b), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_overflow", int'(overflow), 0);
      rst = 1'b0;
      step(1'b0, 1'b1);

      // Single token: one pulse in the following cycle.
      c = cyc;
      exp_q.push_back(c + 1);
      step(1'b1, 1'b1);
      check("t1_pending_during_b", int'(pending), 1);
      step(1'b0, 1'b1);
      check("t1_pending_after", int'(pending), 0);
      repeat (5) step(1'b0, 1'b1);
      check("t1_queue_empty", exp_q.size(), 0);

      // Three back-to-back tokens: pulses spaced GAP+1 apart.
      c = cyc;
      exp_q.push_back(c + 1);
      exp_q.push_back(c + 4);
      exp_q.push_back(c + 7);
      repeat (3) step(1'b1, 1'b1);
      check("t2_pending_peak", int'(pending), 2);
      repeat (8) step(1'b0, 1'b1);
      check("t2_pending_end", int'(pending), 0);
      check("t2_queue_empty", exp_q.size(), 0);

      // Five tokens held back by ready=0, then released.
      repeat (5) step(1'b1, 1'b0);
      check("t3_pending_held", int'(pending), 5);
      c = cyc;
      for (int k = 0; k < 5; k++) exp_q.push_back(c + 3 * k);
      repeat (15) step(1'b0, 1'b1);
      check("t3_pending_end", int'(pending), 0);
      check("t3_queue_empty", exp_q.size(), 0);

      // Eight tokens into a 7-deep queue: one dropped, overflow sticks.
      repeat (7) step(1'b1, 1'b0);
      check("t4_pending_full", int'(pending), 7);
      check("t4_overflow_before", int'(overflow), 0);
      step(1'b1, 1'b0);
      check("t4_pending_sat", int'(pending), 7);
      check("t4_overflow_set", int'(overflow), 1);
      repeat (2) step(1'b0, 1'b0);
      check("t4_overflow_sticky", int'(overflow), 1);
      c = cyc;
      for (int k = 0; k < 7; k++) exp_q.push_back(c + 3 * k);
      repeat (22) step(1'b0, 1'b1);
      check("t4_pending_end", int'(pending), 0);
      check("t4_overflow_end", int'(overflow), 1);
      check("t4_queue_empty", exp_q.size(), 0);

      // Reset mid-burst: everything clears immediately, no later pulses.
      repeat (4) step(1'b1, 1'b0);
      check("t5_pending_before", int'(pending), 4);
      a = 1'b0;
      #2;
      rst   = 1'b1;
      ready = 1'b1;
      #1;
      check("t5_b_in_rst", int'(b), 0);
      check("t5_pending_in_rst", int'(pending), 0);
      check("t5_overflow_in_rst", int'(overflow), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) step(1'b0, 1'b1);
      check("t5_pending_idle", int'(pending), 0);
      check("t5_queue_empty", exp_q.size(), 0);

      // GAP=0 pacer behind a modelled doubler: every token comes out twice.
      n_in = 0;
      owed = 0;
      n_b0 = 0;
      for (int i = 0; i < 300; i++) begin
         if (i < 100 && $urandom_range(99) < 30) begin
            n_in++;
            owed += 2;
         end
         a0 = (owed > 0);
         if (owed > 0) owed--;
         @(posedge clk);
         #1;
      end
      a0 = 1'b0;
      check("t6_b_count", n_b0, 2 * n_in);
      check("t6_overflow", int'(overflow0), 0);
      check("t6_pending_end", int'(pending0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
